y_response_checker: RTL and testbench

//  Receive-side counterpart to the stimulus driver: consumes the DUT result bus y once per

---
 rtl/y_response_checker.sv | 223 ++++++++++++++++++++++
 tb/tb_y_response_checker.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y_response_checker.sv
// -----------------------------------------------------------------------------
// y_response_checker
//
// Receive-side checker for the simulation / on-FPGA self-check harness.
// Expected response vectors are preloaded into an internal FIFO. Once a run is
// armed, each y_valid cycle consumes one vector: the DUT response y is compared
// with the FIFO head. The block accumulates a saturating mismatch count, the
// index of the first failing vector, and a 32-bit MISR signature over every
// compared y.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset (also flushes the FIFO)
//   exp_valid       expected-vector write request
//   exp_data        expected vector
//   exp_ready       FIFO not full
//   start           one-cycle pulse that arms a run (ignored while busy)
//   num_vec         vectors in the run, sampled on start (0 = done at once)
//   y_valid         y is valid this cycle
//   y               DUT response
//   busy            a run is in progress
//   done            run finished; held until the next start or reset
//   pass            done with no mismatches and no starvation
//   starve          sticky: a response arrived while the FIFO was empty
//   mismatch_cnt    failing compares, saturating at 16'hFFFF
//   first_fail_idx  0-based index of the first failure, 16'hFFFF if none
//   signature       MISR over all compared responses
// -----------------------------------------------------------------------------
module y_response_checker #(
  parameter int          WIDTH     = 119,
  parameter int          DEPTH     = 32,
  parameter logic [31:0] MISR_POLY = 32'h04C11DB7,
  parameter logic [31:0] MISR_SEED = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exp_valid,
  input  logic [WIDTH-1:0] exp_data,
  output logic             exp_ready,
  input  logic             start,
  input  logic [15:0]      num_vec,
  input  logic             y_valid,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             starve,
  output logic [15:0]      mismatch_cnt,
  output logic [15:0]      first_fail_idx,
  output logic [31:0]      signature
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              NSLICE   = (WIDTH + 31) / 32;
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [15:0]     NO_FAIL  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Expected-vector FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic full;
  logic empty;
  logic compare;
  logic pop;
  logic push;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign exp_ready = ~full;

  // A compare only happens in RUN; start in IDLE/DONE never consumes y.
  assign compare = (state == RUN) && y_valid;
  assign pop     = compare && !empty;
  // While full, a write is still taken if a pop frees the slot in the same
  // cycle, so a full FIFO can stream with the count held at DEPTH.
  assign push    = exp_valid && (!full || pop);

  // NOTE: the storage array has no reset; only the pointers and count do.
  // Flushing the FIFO is done by clearing those, which keeps the array mappable
  // to RAM and avoids a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= exp_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Compare and signature datapath
  // ---------------------------------------------------------------------------
  // XOR of all 32-bit slices of y, zero-padded up to a whole number of slices.
  function automatic logic [31:0] fold_y(input logic [WIDTH-1:0] v);
    logic [NSLICE*32-1:0] padded;
    logic [31:0]          acc;
    padded             = '0;
    padded[WIDTH-1:0]  = v;
    acc                = '0;
    for (int i = 0; i < NSLICE; i++) begin
      acc ^= padded[i*32 +: 32];
    end
    return acc;
  endfunction

  logic        fail;
  logic        last;
  logic [31:0] sig_next;
  logic [15:0] mismatch_inc;
  logic [15:0] vec_idx;
  logic [15:0] num_vec_q;

  // A starved compare (FIFO empty) counts as a failure.
  assign fail         = compare && (empty || (y != mem[rd_ptr]));
  assign last         = (({1'b0, vec_idx} + 17'd1) == {1'b0, num_vec_q});
  assign sig_next     = {signature[30:0], 1'b0}
                        ^ (signature[31] ? MISR_POLY : 32'h0)
                        ^ fold_y(y);
  assign mismatch_inc = (mismatch_cnt == 16'hFFFF) ? mismatch_cnt
                                                   : mismatch_cnt + 16'd1;

  // ---------------------------------------------------------------------------
  // Run control FSM with registered status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      starve         <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_idx <= NO_FAIL;
      signature      <= MISR_SEED;
      vec_idx        <= '0;
      num_vec_q      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            num_vec_q      <= num_vec;
            vec_idx        <= '0;
            mismatch_cnt   <= '0;
            starve         <= 1'b0;
            first_fail_idx <= NO_FAIL;
            signature      <= MISR_SEED;
            if (num_vec == 16'd0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end

        RUN: begin
          if (compare) begin
            signature <= sig_next;
            vec_idx   <= vec_idx + 16'd1;
            if (empty) begin
              starve <= 1'b1;
            end
            if (fail) begin
              mismatch_cnt <= mismatch_inc;
              if (first_fail_idx == NO_FAIL) begin
                first_fail_idx <= vec_idx;
              end
            end
            // The final compare retires the run at the same edge, so done and
            // the final counters appear together one cycle after the last y.
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (mismatch_cnt == 16'd0) && !starve && !fail;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y_response_checker.sv
// -----------------------------------------------------------------------------
// tb_y_response_checker
//
// Directed bench for y_response_checker. Each run's expected final status is
// pushed into a scoreboard queue when the run is issued; a monitor pops an entry
// whenever done rises and compares the reported status against it. Immediate
// checks cover reset values, flow control, latency and the async reset abort.
// -----------------------------------------------------------------------------
module tb_y_response_checker;

  localparam int W = 119;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          exp_valid = 1'b0;
  logic [W-1:0]  exp_data = '0;
  logic          exp_ready;
  logic          start = 1'b0;
  logic [15:0]   num_vec = '0;
  logic          y_valid = 1'b0;
  logic [W-1:0]  y = '0;
  logic          busy;
  logic          done;
  logic          pass;
  logic          starve;
  logic [15:0]   mismatch_cnt;
  logic [15:0]   first_fail_idx;
  logic [31:0]   signature;

  y_response_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exp_valid      (exp_valid),
    .exp_data       (exp_data),
    .exp_ready      (exp_ready),
    .start          (start),
    .num_vec        (num_vec),
    .y_valid        (y_valid),
    .y              (y),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .starve         (starve),
    .mismatch_cnt   (mismatch_cnt),
    .first_fail_idx (first_fail_idx),
    .signature      (signature)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] mism;
    logic [15:0] ffi;
    logic        pass;
    logic        starve;
    logic [31:0] sig;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference MISR step: fold bit b of y into signature bit b mod 32.
  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [W-1:0] v);
    logic [31:0] f;
    f = '0;
    for (int b = 0; b < W; b++) f[b % 32] ^= v[b];
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  function automatic logic [W-1:0] vec_of(input int i);
    return {23'(i), 32'(i * 7 + 1), 32'hA5A50000 | 32'(i), ~32'(i)};
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: one scoreboard entry per rising edge of done
  // ---------------------------------------------------------------------------
  logic done_q = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      done_q = 1'b0;
    end else begin
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no pending run");
        end else begin
          e = sb.pop_front();
          check($sformatf("run%0d_mismatch_cnt", e.id), 32'(mismatch_cnt), 32'(e.mism));
          check($sformatf("run%0d_first_fail_idx", e.id), 32'(first_fail_idx), 32'(e.ffi));
          check($sformatf("run%0d_pass", e.id), 32'(pass), 32'(e.pass));
          check($sformatf("run%0d_starve", e.id), 32'(starve), 32'(e.starve));
          check($sformatf("run%0d_signature", e.id), signature, e.sig);
        end
      end
      done_q = done;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    exp_valid = 1'b1;
    exp_data  = v;
    cyc();
    exp_valid = 1'b0;
  endtask

  task automatic start_run(input logic [15:0] n);
    start   = 1'b1;
    num_vec = n;
    cyc();
    start   = 1'b0;
  endtask

  task automatic send_y(input logic [W-1:0] v);
    y_valid = 1'b1;
    y       = v;
    cyc();
    y_valid = 1'b0;
  endtask

  task automatic expect_run(input int id, input logic [15:0] mism, input logic [15:0] ffi,
                            input logic p, input logic st, input logic [31:0] sig);
    exp_t e;
    e.id = id; e.mism = mism; e.ffi = ffi; e.pass = p; e.starve = st; e.sig = sig;
    sb.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] va, vb, vc, vd, ve;
    logic [31:0]  sig;
    int           waited;

    va = {23'h012345, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
    vb = {23'h7F00FF, 32'hCAFEF00D, 32'h0F0F0F0F, 32'h00000001};
    vc = {23'h000001, 32'h00000000, 32'hFFFFFFFF, 32'h12345678};
    vd = {23'h5A5A5A, 32'h11111111, 32'h22222222, 32'h33333333};
    ve = {23'h2AAAAA, 32'h44444444, 32'h55555555, 32'h66666666};

    // Reset values
    repeat (2) cyc();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_pass", 32'(pass), 32'd0);
    check("reset_starve", 32'(starve), 32'd0);
    check("reset_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    check("reset_first_fail_idx", 32'(first_fail_idx), 32'h0000FFFF);
    check("reset_signature", signature, 32'hFFFFFFFF);
    check("reset_exp_ready", 32'(exp_ready), 32'd1);
    rst_n = 1'b1;
    cyc();

    // T1: all three match; y_valid in the start cycle is ignored
    load(va); load(vb); load(vc);
    sig = misr_step(misr_step(misr_step(32'hFFFFFFFF, va), vb), vc);
    expect_run(1, 16'd0, 16'hFFFF, 1'b1, 1'b0, sig);
    start = 1'b1; num_vec = 16'd3; y_valid = 1'b1; y = vd;
    cyc();
    start = 1'b0; y_valid = 1'b0;
    check("t1_busy_after_start", 32'(busy), 32'd1);
    send_y(va); send_y(vb);
    check("t1_not_done_early", 32'(done), 32'd0);
    send_y(vc);
    check("t1_done_latency", 32'(done), 32'd1);
    check("t1_busy_clear", 32'(busy), 32'd0);
    cyc();

    // T2: middle vector corrupted by one bit
    load(va); load(vb); load(vc);
    sig = misr_step(misr_step(misr_step(32'hFFFFFFFF, va), vb ^ W'(1)), vc);
    expect_run(2, 16'd1, 16'd1, 1'b0, 1'b0, sig);
    start_run(16'd3);
    send_y(va); send_y(vb ^ W'(1)); send_y(vc);
    check("t2_done_latency", 32'(done), 32'd1);
    cyc();

    // T3: one vector loaded, two responses -> second starves
    load(vd);
    sig = misr_step(misr_step(32'hFFFFFFFF, vd), ve);
    expect_run(3, 16'd1, 16'd1, 1'b0, 1'b1, sig);
    start_run(16'd2);
    send_y(vd); send_y(ve);
    check("t3_done_latency", 32'(done), 32'd1);
    cyc();

    // T4: fill to 32, drop the 33rd, then push+pop while full
    for (int i = 0; i < 32; i++) begin
      if (i == 31) check("t4_ready_before_32nd", 32'(exp_ready), 32'd1);
      load(vec_of(i));
    end
    check("t4_full_after_32", 32'(exp_ready), 32'd0);
    // 33rd write is dropped; y_valid outside RUN must not pop
    exp_valid = 1'b1; exp_data = vec_of(32); y_valid = 1'b1; y = vec_of(0);
    cyc();
    exp_valid = 1'b0; y_valid = 1'b0;
    check("t4_full_after_drop", 32'(exp_ready), 32'd0);
    sig = 32'hFFFFFFFF;
    for (int i = 0; i < 32; i++) sig = misr_step(sig, vec_of(i));
    sig = misr_step(sig, vec_of(33));
    expect_run(4, 16'd0, 16'hFFFF, 1'b1, 1'b0, sig);
    start_run(16'd33);
    exp_valid = 1'b1; exp_data = vec_of(33); y_valid = 1'b1; y = vec_of(0);
    cyc();
    exp_valid = 1'b0; y_valid = 1'b0;
    check("t4_full_after_push_pop", 32'(exp_ready), 32'd0);
    for (int i = 1; i < 32; i++) send_y(vec_of(i));
    send_y(vec_of(33));
    check("t4_done_latency", 32'(done), 32'd1);
    check("t4_empty_ready", 32'(exp_ready), 32'd1);
    cyc();

    // T5: async reset after 2 of 4 compares
    for (int i = 40; i < 44; i++) load(vec_of(i));
    start_run(16'd4);
    send_y(vec_of(40)); send_y(vec_of(41));
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    check("t5_first_fail_idx", 32'(first_fail_idx), 32'h0000FFFF);
    check("t5_signature", signature, 32'hFFFFFFFF);
    check("t5_exp_ready", 32'(exp_ready), 32'd1);
    cyc();
    rst_n = 1'b1;
    cyc();

    // T6: zero-length run from IDLE
    expect_run(6, 16'd0, 16'hFFFF, 1'b1, 1'b0, 32'hFFFFFFFF);
    start_run(16'd0);
    check("t6_done", 32'(done), 32'd1);
    check("t6_pass", 32'(pass), 32'd1);
    check("t6_signature", signature, 32'hFFFFFFFF);
    cyc();

    // T7: FIFO flushed by reset -> both compares starve; start in RUN ignored
    sig = misr_step(misr_step(32'hFFFFFFFF, vec_of(50)), vec_of(51));
    expect_run(7, 16'd2, 16'd0, 1'b0, 1'b1, sig);
    start_run(16'd2);
    start = 1'b1; num_vec = 16'd0; y_valid = 1'b1; y = vec_of(50);
    cyc();
    start = 1'b0; y_valid = 1'b0;
    check("t7_start_in_run_ignored", 32'(busy), 32'd1);
    send_y(vec_of(51));
    check("t7_done_latency", 32'(done), 32'd1);

    // Drain the scoreboard with a bounded wait
    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      cyc();
      waited++;
    end
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL run%0d_timeout: got no done, expected done within bound", e.id);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
